// File: rtl/branch_pkg.sv
// Shared types for the branch-resolution sequencer: branch encodings and FSM states.
package branch_pkg;

  typedef enum logic [2:0] {
    T_NONE = 3'd0,
    T_BEQ  = 3'd1,
    T_BNE  = 3'd2,
    T_BLT  = 3'd3,
    T_BGE  = 3'd4,
    T_BLTU = 3'd5,
    T_BGEU = 3'd6,
    T_JAL  = 3'd7
  } br_type_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ALU = 2'd1,
    REDIRECT = 2'd2,
    FLUSH    = 2'd3
  } seq_state_t;

  localparam br_type_t BR_JAL  = T_JAL;
  localparam br_type_t BR_NONE = T_NONE;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch-condition evaluator: maps branch type and ALU compare flags to taken.
module branch_cond
  import branch_pkg::*;
(
  input  br_type_t i_type,
  input  logic     i_zero,
  input  logic     i_neg,
  input  logic     i_ltu,
  output logic     o_taken
);

  always_comb begin
    o_taken = 1'b0;
    case (i_type)
      T_BEQ:   o_taken = i_zero;
      T_BNE:   o_taken = !i_zero;
      T_BLT:   o_taken = i_neg;
      T_BGE:   o_taken = !i_neg;
      T_BLTU:  o_taken = i_ltu;
      T_BGEU:  o_taken = !i_ltu;
      T_JAL:   o_taken = 1'b1;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_sequencer.sv
// Multi-cycle conditional-branch sequencer: ALU compare launch, condition evaluation,
// one-cycle PC redirect, flush window, front-end stall and saturating perf counters.
module branch_sequencer
  import branch_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int TIMEOUT      = 8,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [2:0]       br_type,
  input  logic [31:0]      br_pc,
  input  logic [31:0]      br_imm,
  output logic             alu_req,
  input  logic             alu_done,
  input  logic             alu_zero,
  input  logic             alu_neg,
  input  logic             alu_ltu,
  output logic             pc_redirect_valid,
  output logic [31:0]      pc_redirect_target,
  output logic             misalign,
  output logic             flush,
  output logic             stall,
  output logic             err,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] not_taken_cnt
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [FW-1:0] F_LAST = FW'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  seq_state_t       r_state;
  seq_state_t       w_state_nxt;
  br_type_t         r_type;
  logic [31:0]      r_target;
  logic [TW-1:0]    r_tmo;
  logic [FW-1:0]    r_fcnt;
  logic             r_br_ready, r_alu_req, r_redirect, r_misalign, r_flush, r_stall, r_err;
  logic [31:0]      r_target_o;
  logic [CNT_W-1:0] r_taken_cnt, r_not_taken_cnt;

  logic             w_accept;
  logic             w_taken;
  logic             w_tmo_last;
  logic [31:0]      w_target_acc;
  logic [31:0]      w_target_nxt;
  br_type_t         w_in_type;

  assign w_in_type    = br_type_t'(br_type);
  assign w_accept     = br_valid && (r_state == IDLE);
  assign w_tmo_last   = (r_tmo == T_LAST);
  assign w_target_acc = br_pc + br_imm;
  assign w_target_nxt = w_accept ? w_target_acc : r_target;

  branch_cond u_cond (
    .i_type  (r_type),
    .i_zero  (alu_zero),
    .i_neg   (alu_neg),
    .i_ltu   (alu_ltu),
    .o_taken (w_taken)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_in_type == BR_JAL)       w_state_nxt = REDIRECT;
          else if (w_in_type != BR_NONE) w_state_nxt = WAIT_ALU;
        end
      end
      WAIT_ALU: begin
        // A done on the final timeout cycle still resolves the branch normally.
        if (alu_done)        w_state_nxt = w_taken ? REDIRECT : IDLE;
        else if (w_tmo_last) w_state_nxt = IDLE;
      end
      REDIRECT: w_state_nxt = (FLUSH_CYCLES > 1) ? FLUSH : IDLE;
      FLUSH:    if (r_fcnt == F_LAST) w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= IDLE;
      r_type          <= T_NONE;
      r_target        <= '0;
      r_tmo           <= '0;
      r_fcnt          <= '0;
      r_br_ready      <= 1'b1;
      r_alu_req       <= 1'b0;
      r_redirect      <= 1'b0;
      r_target_o      <= '0;
      r_misalign      <= 1'b0;
      r_flush         <= 1'b0;
      r_stall         <= 1'b0;
      r_err           <= 1'b0;
      r_taken_cnt     <= '0;
      r_not_taken_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_type   <= w_in_type;
        r_target <= w_target_acc;
      end
      r_tmo  <= (r_state == WAIT_ALU) ? r_tmo + 1'b1 : '0;
      r_fcnt <= (r_state == FLUSH) ? r_fcnt + 1'b1 : '0;

      if (r_state == WAIT_ALU) begin
        if ((alu_done && !w_taken) || (!alu_done && w_tmo_last))
          r_not_taken_cnt <= sat_inc(r_not_taken_cnt);
        if (!alu_done && w_tmo_last)
          r_err <= 1'b1;
      end
      if (r_state == REDIRECT)
        r_taken_cnt <= sat_inc(r_taken_cnt);

      r_br_ready <= (w_state_nxt == IDLE);
      r_stall    <= (w_state_nxt != IDLE);
      r_alu_req  <= (w_state_nxt == WAIT_ALU);
      r_redirect <= (w_state_nxt == REDIRECT);
      r_target_o <= (w_state_nxt == REDIRECT) ? w_target_nxt : '0;
      r_misalign <= (w_state_nxt == REDIRECT) && (w_target_nxt[1:0] != 2'b00);
      r_flush    <= (w_state_nxt == REDIRECT) || (w_state_nxt == FLUSH);
    end
  end

  assign br_ready           = r_br_ready;
  assign alu_req            = r_alu_req;
  assign pc_redirect_valid  = r_redirect;
  assign pc_redirect_target = r_target_o;
  assign misalign           = r_misalign;
  assign flush              = r_flush;
  assign stall              = r_stall;
  assign err                = r_err;
  assign taken_cnt          = r_taken_cnt;
  assign not_taken_cnt      = r_not_taken_cnt;

endmodule

// File: tb/tb_branch_sequencer.sv
// Bench for branch_sequencer: directed scenarios plus randomized branches checked
// against an operand-level reference model of branch resolution.
module tb_branch_sequencer;
  localparam int FC = 2;
  localparam int TO = 8;
  localparam int CW = 4;
  localparam logic [CW-1:0] CMAX = '1;

  logic          clk = 1'b0;
  logic          rst;
  logic          br_valid, br_ready;
  logic [2:0]    br_type;
  logic [31:0]   br_pc, br_imm;
  logic          alu_req, alu_done, alu_zero, alu_neg, alu_ltu;
  logic          pc_redirect_valid;
  logic [31:0]   pc_redirect_target;
  logic          misalign, flush, stall, err;
  logic [CW-1:0] taken_cnt, not_taken_cnt;

  int n_pass  = 0;
  int n_total = 0;

  logic [CW-1:0] m_taken, m_nt;
  logic          m_err;

  always #5 clk = ~clk;

  branch_sequencer #(.FLUSH_CYCLES(FC), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .br_valid(br_valid), .br_ready(br_ready), .br_type(br_type),
    .br_pc(br_pc), .br_imm(br_imm),
    .alu_req(alu_req), .alu_done(alu_done), .alu_zero(alu_zero),
    .alu_neg(alu_neg), .alu_ltu(alu_ltu),
    .pc_redirect_valid(pc_redirect_valid), .pc_redirect_target(pc_redirect_target),
    .misalign(misalign), .flush(flush), .stall(stall), .err(err),
    .taken_cnt(taken_cnt), .not_taken_cnt(not_taken_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: branch outcome from the source operands themselves.
  function automatic bit model_taken(input int t, input logic [31:0] a, input logic [31:0] b);
    case (t)
      1: return a == b;
      2: return a != b;
      3: return $signed(a) < $signed(b);
      4: return $signed(a) >= $signed(b);
      5: return a < b;
      6: return a >= b;
      7: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [CW-1:0] sat(input logic [CW-1:0] v);
    return (v == CMAX) ? v : v + 1'b1;
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_ready"}, br_ready, 1);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_flush"}, flush, 0);
    chk({tag, "_req"}, alu_req, 0);
    chk({tag, "_redir"}, pc_redirect_valid, 0);
    chk({tag, "_tgt"}, pc_redirect_target, 0);
    chk({tag, "_tcnt"}, taken_cnt, m_taken);
    chk({tag, "_ntcnt"}, not_taken_cnt, m_nt);
    chk({tag, "_err"}, err, m_err);
  endtask

  // delay = index of the WAIT_ALU cycle carrying alu_done; delay >= TO means never.
  task automatic branch(input string tag, input int t, input logic [31:0] pc,
                        input logic [31:0] imm, input logic [31:0] a,
                        input logic [31:0] b, input int delay);
    logic [31:0] tgt;
    bit tk, done;
    tgt = pc + imm;
    tk  = 1'b0;
    chk({tag, "_pre_ready"}, br_ready, 1);
    br_valid = 1'b1;
    br_type  = t[2:0];
    br_pc    = pc;
    br_imm   = imm;
    step();
    br_valid = 1'b0;
    br_type  = $urandom_range(0, 7);
    br_pc    = $urandom;
    br_imm   = $urandom;
    if (t == 7) begin
      tk = 1'b1;
    end else if (t != 0) begin
      done = 1'b0;
      for (int k = 0; k < TO; k++) begin
        chk({tag, "_wait_req"}, alu_req, 1);
        chk({tag, "_wait_stall"}, stall, 1);
        chk({tag, "_wait_ready"}, br_ready, 0);
        chk({tag, "_wait_redir"}, pc_redirect_valid, 0);
        if (k == delay) begin
          alu_done = 1'b1;
          alu_zero = (a == b);
          alu_neg  = ($signed(a) < $signed(b));
          alu_ltu  = (a < b);
        end
        step();
        alu_done = 1'b0;
        if (k == delay) begin
          done = 1'b1;
          break;
        end
      end
      if (done) tk = model_taken(t, a, b);
      else      m_err = 1'b1;
      if (!tk) m_nt = sat(m_nt);
    end
    if (tk) begin
      chk({tag, "_redir"}, pc_redirect_valid, 1);
      chk({tag, "_tgt"}, pc_redirect_target, tgt);
      chk({tag, "_mis"}, misalign, (tgt[1:0] != 2'b00));
      chk({tag, "_rflush"}, flush, 1);
      chk({tag, "_rstall"}, stall, 1);
      chk({tag, "_rreq"}, alu_req, 0);
      chk({tag, "_rready"}, br_ready, 0);
      step();
      for (int j = 0; j < FC - 1; j++) begin
        chk({tag, "_fflush"}, flush, 1);
        chk({tag, "_fredir"}, pc_redirect_valid, 0);
        chk({tag, "_ftgt"}, pc_redirect_target, 0);
        chk({tag, "_fstall"}, stall, 1);
        step();
      end
      m_taken = sat(m_taken);
    end
    check_idle({tag, "_post"});
  endtask

  initial begin
    logic [31:0] a, b;
    int t, d;
    rst = 1'b1; br_valid = 1'b0; br_type = '0; br_pc = '0; br_imm = '0;
    alu_done = 1'b0; alu_zero = 1'b0; alu_neg = 1'b0; alu_ltu = 1'b0;
    m_taken = '0; m_nt = '0; m_err = 1'b0;
    step();
    step();
    check_idle("reset");
    chk("reset_mis", misalign, 0);
    rst = 1'b0;
    step();

    branch("beq", 1, 32'h100, 32'h20, 32'd5, 32'd5, 0);
    branch("bne_delay", 2, 32'h300, 32'h40, 32'd9, 32'd9, 3);
    branch("bltu", 5, 32'hFFFF_FFF0, 32'h20, 32'h8000_0000, 32'h0, 0);
    branch("bgeu", 6, 32'hFFFF_FFF0, 32'h20, 32'h8000_0000, 32'h0, 0);
    branch("jal", 7, 32'h200, 32'hFFFF_FFFE, 32'h0, 32'h0, 0);
    branch("none", 0, 32'h400, 32'h8, 32'h0, 32'h0, 0);
    branch("blt_last", 3, 32'h500, 32'h10, 32'hFFFF_FFFF, 32'h1, TO - 1);
    branch("bge_nt", 4, 32'h600, 32'h10, 32'hFFFF_FFFF, 32'h1, 1);
    branch("timeout", 1, 32'h700, 32'h10, 32'h1, 32'h1, TO);

    for (int i = 0; i < 40; i++) begin
      t = $urandom_range(0, 7);
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      d = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, 4);
      branch("rand", t, $urandom, $urandom, a, b, d);
    end

    // Reset while in the flush window.
    br_valid = 1'b1; br_type = 3'd7; br_pc = 32'h800; br_imm = 32'h4;
    step();
    br_valid = 1'b0;
    chk("rstf_redir", pc_redirect_valid, 1);
    step();
    chk("rstf_inflush", flush, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_taken = '0; m_nt = '0; m_err = 1'b0;
    check_idle("rstf");
    chk("rstf_mis", misalign, 0);

    for (int i = 0; i < 17; i++)
      branch("sat_t", 7, $urandom, $urandom, 32'h0, 32'h0, 0);
    chk("sat_taken_max", taken_cnt, CMAX);
    for (int i = 0; i < 17; i++)
      branch("sat_nt", 2, $urandom, $urandom, 32'h33, 32'h33, 0);
    chk("sat_nt_max", not_taken_cnt, CMAX);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
Multi-cycle controller that sequences conditional-branch resolution in the rv32 core.
- Accepts a branch from decode and launches the compare on the shared ALU.
- Waits for the ALU result, evaluates the branch condition and computes the target.
- Issues a one-cycle PC redirect followed by a pipeline flush window.
- Stalls the front end while busy and keeps saturating taken/not-taken performance counters.

Parameters:
FLUSH_CYCLES, 2, cycles flush is asserted per taken branch (>=1, includes redirect cycle)
TIMEOUT, 8, max cycles in WAIT_ALU before abort (>=1)
CNT_W, 16, width of performance counters

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
br_valid  in  1  decode presents a branch
br_ready  out  1  sequencer can accept (high only in IDLE)
br_type  in  3  0 none, 1 beq, 2 bne, 3 blt, 4 bge, 5 bltu, 6 bgeu, 7 jal (unconditional)
br_pc  in  32  PC of branch instruction
br_imm  in  32  sign-extended offset
alu_req  out  1  request ALU compare (rs1 - rs2)
alu_done  in  1  ALU result valid this cycle
alu_zero  in  1  rs1 == rs2
alu_neg  in  1  rs1 < rs2 signed
alu_ltu  in  1  rs1 < rs2 unsigned
pc_redirect_valid  out  1  one-cycle redirect strobe
pc_redirect_target  out  32  br_pc + br_imm, mod 2^32
misalign  out  1  pulses with redirect when target[1:0] != 0
flush  out  1  squash younger instructions
stall  out  1  hold fetch/decode
err  out  1  sticky ALU timeout
taken_cnt  out  CNT_W  saturating count of taken branches
not_taken_cnt  out  CNT_W  saturating count of not-taken and aborted branches

Behaviour:
Reset (rst high at a rising edge):
- State IDLE.
- All outputs 0 except br_ready = 1.
- Counters 0, err 0, latched registers 0.
- Reset overrides any state, including mid-WAIT_ALU and mid-flush; redirect and flush drop the cycle after reset is sampled.

States:
- IDLE
  - br_ready = 1; stall = 0.
  - Handshake: accept when br_valid && br_ready. Latch type, pc, imm; target = pc + imm (32-bit wrap, no carry out).
  - Type 0: accepted, no effect, stay IDLE.
  - Type 7: go to REDIRECT directly, no ALU request.
  - Types 1-6: go to WAIT_ALU.
- WAIT_ALU
  - alu_req = 1 every cycle until alu_done is sampled high (alu_done in other states is ignored).
  - Timeout counter clears on entry.
  - On alu_done, evaluate flags from that same cycle:
    - beq: zero
    - bne: !zero
    - blt: neg
    - bge: !neg
    - bltu: ltu
    - bgeu: !ltu
  - Taken: go to REDIRECT. Not taken: not_taken_cnt++, go to IDLE.
  - If TIMEOUT cycles elapse with no alu_done: err <= 1 (sticky until reset), not_taken_cnt++, go to IDLE.
  - alu_done on the final timeout cycle counts as done.
- REDIRECT (exactly 1 cycle)
  - pc_redirect_valid = 1, flush = 1, target driven, misalign = (target[1:0] != 0).
  - taken_cnt++.
  - Next state: FLUSH if FLUSH_CYCLES > 1, else IDLE.
- FLUSH
  - flush = 1 for FLUSH_CYCLES-1 cycles, then IDLE.

Always true:
- stall = (state != IDLE).
- br_ready = (state == IDLE).
- pc_redirect_target is 0 outside REDIRECT.

Latency:
- Conditional, ALU done at the first WAIT_ALU cycle: accept at edge N, redirect visible in cycle N+2.
- jal: redirect in cycle N+1.
- Back-to-back: a new branch can be accepted in the first IDLE cycle after completion.

Counters: saturate at all-ones and never wrap.

Decomposition:
- Shared package branch_pkg:
  - br_type_t enum (encodings above)
  - seq_state_t enum {IDLE, WAIT_ALU, REDIRECT, FLUSH}
  - BR_JAL / BR_NONE constants
- One sub-module: branch_cond, a purely combinational evaluator of (br_type, zero, neg, ltu) to taken. The sequencer instantiates it.

Test Plan:
- beq, pc=0x100, imm=0x20; alu_done=1, zero=1 in the first WAIT_ALU cycle -> pc_redirect_valid for exactly 1 cycle with target 0x120, flush high 2 cycles, taken_cnt=1, br_ready back high the next cycle.
- bne with zero=1; alu_done delayed 3 cycles -> alu_req high 4 cycles, no redirect, not_taken_cnt=1, stall high for the entire wait.
- bltu vs bgeu with neg=1, ltu=0 -> bltu not taken, bgeu taken; pc=0xFFFFFFF0, imm=0x20 gives target 0x00000010 (wrap).
- jal, pc=0x200, imm=0xFFFFFFFE -> no alu_req, redirect next cycle to 0x1FE with misalign=1.
- alu_done never asserted -> after 8 WAIT_ALU cycles err=1 and stays 1 across later branches; not_taken_cnt incremented; IDLE.
- rst asserted during the FLUSH cycle -> next cycle flush=0, stall=0, br_ready=1, counters 0, err 0; preload counters to all-ones and confirm no wrap.
